// File: rtl/board_pkg.sv
// Shared definitions for the tic-tac-toe board writer: cell codes, FSM
// encoding, the table of winning lines and small board access helpers.
package board_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P1    = 2'd1;
  localparam logic [1:0] P2    = 2'd2;
  localparam logic [1:0] DRAW  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_CHECK   = 3'd2,
    S_RELEASE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  // Rows, columns, then the two diagonals, each as three cell indices.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_get(input logic [17:0] b, input logic [3:0] k);
    return b[{k, 1'b0} +: 2];
  endfunction

  function automatic logic is_onehot9(input logic [8:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

  // Index of the set bit; only meaningful when the vector is one-hot.
  function automatic logic [3:0] onehot_index(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser for the nine cell buttons followed by a saturating
// stability counter. stable is high once the synchronised vector has held
// the same value for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] key,
  output logic [8:0] ks,
  output logic       stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [8:0]       key_p0;
  logic [8:0]       key_p1;
  logic [8:0]       ks_prev;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw buttons and count how long the vector stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0  <= '0;
      key_p1  <= '0;
      ks_prev <= '0;
      cnt     <= '0;
    end else begin
      key_p0  <= key;
      key_p1  <= key_p0;
      ks_prev <= key_p1;
      if (key_p1 != ks_prev) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign ks = key_p1;
  // A change visible this cycle must not ride on the old saturated count.
  assign stable = (cnt == CNT_MAX) && (key_p1 == ks_prev);

endmodule

// File: rtl/board_input_ctrl.sv
// Writer side of the 18-bit tic-tac-toe board bus. Debounces the cell
// buttons, validates a press, writes the mover's code and alternates turns.
// Define WIN_CHECK_EN to add line/draw detection (game_over, winner);
// without it both outputs stay 0 and play continues until the board is full.
module board_input_ctrl
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  key,
  input  logic        key_clr,
  output logic [17:0] board,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        move_ok,
  output logic        move_err
);

  logic [8:0] ks;
  logic       stable;
  logic       press_onehot;
  logic [3:0] press_idx;
  state_t     state;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .ks     (ks),
    .stable (stable)
  );

  assign press_onehot = is_onehot9(ks);
  assign press_idx    = onehot_index(ks);

`ifdef WIN_CHECK_EN
  logic       line_win;
  logic [1:0] line_code;
  logic       board_full;

  // Scan lines in table order; the first completed line names the winner.
  always_comb begin
    line_win   = 1'b0;
    line_code  = EMPTY;
    board_full = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (!line_win &&
          cell_get(board, WIN_LINES[l][0]) != EMPTY &&
          cell_get(board, WIN_LINES[l][0]) == cell_get(board, WIN_LINES[l][1]) &&
          cell_get(board, WIN_LINES[l][0]) == cell_get(board, WIN_LINES[l][2])) begin
        line_win  = 1'b1;
        line_code = cell_get(board, WIN_LINES[l][0]);
      end
    end
    for (int c = 0; c < 9; c++) begin
      if (cell_get(board, 4'(c)) == EMPTY) board_full = 1'b0;
    end
  end
`else
  assign game_over = 1'b0;
  assign winner    = 2'd0;
`endif

  // Move FSM, board register and registered result pulses; key_clr has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      board     <= '0;
      turn      <= 1'b0;
      move_ok   <= 1'b0;
      move_err  <= 1'b0;
`ifdef WIN_CHECK_EN
      game_over <= 1'b0;
      winner    <= 2'd0;
`endif
    end else begin
      move_ok  <= 1'b0;
      move_err <= 1'b0;
      if (key_clr) begin
        board     <= '0;
        turn      <= 1'b0;
`ifdef WIN_CHECK_EN
        game_over <= 1'b0;
        winner    <= 2'd0;
`endif
        state     <= S_RELEASE;
      end else begin
        case (state)
          S_IDLE: begin
            if (stable && ks != 9'd0) state <= S_APPLY;
          end
          S_APPLY: begin
            if (!press_onehot || cell_get(board, press_idx) != EMPTY) begin
              move_err <= 1'b1;
              state    <= S_RELEASE;
            end else begin
              board[{press_idx, 1'b0} +: 2] <= turn ? P2 : P1;
              turn    <= ~turn;
              move_ok <= 1'b1;
`ifdef WIN_CHECK_EN
              state   <= S_CHECK;
`else
              state   <= S_RELEASE;
`endif
            end
          end
`ifdef WIN_CHECK_EN
          S_CHECK: begin
            if (line_win) begin
              game_over <= 1'b1;
              winner    <= line_code;
              state     <= S_OVER;
            end else if (board_full) begin
              game_over <= 1'b1;
              winner    <= DRAW;
              state     <= S_OVER;
            end else begin
              state <= S_RELEASE;
            end
          end
          S_OVER: begin
            state <= S_OVER;
          end
`endif
          S_RELEASE: begin
            if (stable && ks == 9'd0) state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
